// File: rtl/inst_encoder_if.sv
// Handshake bundle between a field producer, the instruction encoder, and the
// instruction-memory load logic. The master drives fields and out_ready.
interface inst_encoder_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_class;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [11:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_inst;
  logic [ADDR_W-1:0] out_addr;

  modport master (
    output in_valid, in_class, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    output out_ready,
    input  in_ready, out_valid, out_inst, out_addr
  );

  modport slave (
    input  in_valid, in_class, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    input  out_ready,
    output in_ready, out_valid, out_inst, out_addr
  );
endinterface

// File: rtl/inst_encoder.sv
// Packs decoded RV32 fields into instruction words and streams them with an
// auto-incrementing, wrapping byte address through an output reg + skid buffer.
module inst_encoder #(
  parameter int unsigned       ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE   = '0,
  parameter int unsigned       DEPTH  = 64
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  inst_encoder_if.slave  bus,
  output logic           err_illegal
);

  localparam logic [6:0] OP_REGALU = 7'b0110011;
  localparam logic [6:0] OP_IMMALU = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_PAUSE  = 7'b0001111;
  localparam logic [ADDR_W-1:0] LAST_ADDR = BASE + ADDR_W'(4 * (DEPTH - 1));

  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_inst_q,  out_inst_d;
  logic              skid_valid_q, skid_valid_d;
  logic [31:0]       skid_inst_q, skid_inst_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic              err_q,       err_d;

  logic [31:0] enc_word;
  logic        enc_legal;
  logic        accept;
  logic        xfer;

  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    case (bus.in_class)
      3'd0: enc_word = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, OP_REGALU};
      3'd1: begin
        // Shift-immediate forms carry funct7 in the upper immediate bits.
        if (bus.in_funct3 == 3'b001 || bus.in_funct3 == 3'b101)
          enc_word = {bus.in_funct7, bus.in_imm[4:0], bus.in_rs1, bus.in_funct3, bus.in_rd, OP_IMMALU};
        else
          enc_word = {bus.in_imm, bus.in_rs1, bus.in_funct3, bus.in_rd, OP_IMMALU};
      end
      3'd2: enc_word = {bus.in_imm, bus.in_rs1, bus.in_funct3, bus.in_rd, OP_LOAD};
      3'd3: enc_word = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_imm[4:0], OP_STORE};
      3'd4: enc_word = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, OP_PAUSE};
      default: enc_legal = 1'b0;
    endcase
  end

  // Handshakes: a beat moves on a rising edge where valid && ready are both 1.
  // in_ready depends only on registered skid state and reset, never on in_valid.
  assign bus.in_ready  = !skid_valid_q && !reset;
  assign accept        = bus.in_valid && bus.in_ready;
  assign xfer          = out_valid_q && bus.out_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_inst  = out_inst_q;
  assign bus.out_addr  = addr_q;
  assign err_illegal   = err_q;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_inst_d   = out_inst_q;
    skid_valid_d = skid_valid_q;
    skid_inst_d  = skid_inst_q;
    addr_d       = addr_q;
    err_d        = err_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (xfer)
        addr_d = (addr_q == LAST_ADDR) ? BASE : addr_q + ADDR_W'(4);
      if (accept && !enc_legal)
        err_d = 1'b1;
      if (xfer || !out_valid_q) begin
        if (skid_valid_q) begin
          out_valid_d  = 1'b1;
          out_inst_d   = skid_inst_q;
          skid_valid_d = 1'b0;
        end else if (accept && enc_legal) begin
          out_valid_d = 1'b1;
          out_inst_d  = enc_word;
        end else begin
          out_valid_d = 1'b0;
        end
      end else if (accept && enc_legal) begin
        skid_valid_d = 1'b1;
        skid_inst_d  = enc_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_inst_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_inst_q  <= '0;
      addr_q       <= BASE;
      err_q        <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_inst_q   <= out_inst_d;
      skid_valid_q <= skid_valid_d;
      skid_inst_q  <= skid_inst_d;
      addr_q       <= addr_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: encodings, backpressure, wrap, illegal
// class, flush and mid-stream reset, with a small window (DEPTH=4).
module tb_inst_encoder;

  logic clk;
  logic reset;
  logic flush;
  logic err_illegal;
  int   n_pass;
  int   n_total;

  inst_encoder_if #(.ADDR_W(32)) bus ();

  inst_encoder #(
    .ADDR_W(32),
    .BASE  (32'h0),
    .DEPTH (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .bus        (bus.slave),
    .err_illegal(err_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] cls, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [11:0] imm);
    bus.in_class  = cls;
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_funct3 = f3;
    bus.in_funct7 = f7;
    bus.in_imm    = imm;
    bus.in_valid  = 1'b1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    reset   = 1'b1;
    flush   = 1'b0;
    bus.out_ready = 1'b0;
    drive(3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0);
    idle();

    // Reset state
    tick();
    check("rst_in_ready_low", 32'(bus.in_ready), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_addr", bus.out_addr, 32'h0);
    check("rst_out_inst", bus.out_inst, 32'h0);
    check("rst_err", 32'(err_illegal), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Streaming encodings, also exercises wrap 0,4,8,C,0
    bus.out_ready = 1'b1;
    drive(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 12'd0);
    tick();
    check("regalu_inst", bus.out_inst, 32'h002081B3);
    check("regalu_addr", bus.out_addr, 32'h0);
    check("regalu_valid", 32'(bus.out_valid), 32'd1);
    drive(3'd1, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 12'hFFF);
    tick();
    check("immalu_inst", bus.out_inst, 32'hFFF00293);
    check("immalu_addr", bus.out_addr, 32'h4);
    drive(3'd2, 5'd4, 5'd1, 5'd0, 3'b010, 7'd0, 12'd4);
    tick();
    check("load_inst", bus.out_inst, 32'h0040A203);
    check("load_addr", bus.out_addr, 32'h8);
    drive(3'd3, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 12'd8);
    tick();
    check("store_inst", bus.out_inst, 32'h0020A423);
    check("store_addr", bus.out_addr, 32'hC);
    drive(3'd1, 5'd1, 5'd1, 5'd0, 3'b101, 7'b0100000, 12'd3);
    tick();
    check("shift_inst", bus.out_inst, 32'h4030D093);
    check("wrap_addr", bus.out_addr, 32'h0);
    drive(3'd4, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0);
    tick();
    check("pause_inst", bus.out_inst, 32'h0000000F);
    check("pause_addr", bus.out_addr, 32'h4);
    idle();
    tick();
    check("drain_valid", 32'(bus.out_valid), 32'd0);
    check("drain_addr", bus.out_addr, 32'h8);

    // Backpressure: A to output, B to skid, C refused until in_ready returns
    do_reset();
    bus.out_ready = 1'b0;
    drive(3'd0, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 12'd0);
    tick();
    check("bp_a_inst", bus.out_inst, 32'h003100B3);
    check("bp_a_in_ready", 32'(bus.in_ready), 32'd1);
    drive(3'd2, 5'd2, 5'd3, 5'd0, 3'b010, 7'd0, 12'h010);
    tick();
    check("bp_skid_in_ready", 32'(bus.in_ready), 32'd0);
    check("bp_stall_inst", bus.out_inst, 32'h003100B3);
    drive(3'd3, 5'd0, 5'd6, 5'd5, 3'd0, 7'd0, 12'hFE0);
    tick();
    check("bp_hold_inst", bus.out_inst, 32'h003100B3);
    check("bp_hold_addr", bus.out_addr, 32'h0);
    check("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    tick();
    check("bp_b_inst", bus.out_inst, 32'h0101A103);
    check("bp_b_addr", bus.out_addr, 32'h4);
    check("bp_b_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    idle();
    check("bp_c_inst", bus.out_inst, 32'hFE530023);
    check("bp_c_addr", bus.out_addr, 32'h8);
    tick();
    check("bp_done_valid", 32'(bus.out_valid), 32'd0);
    check("bp_done_addr", bus.out_addr, 32'hC);

    // Illegal class: handshake completes, no word, address held, sticky error
    drive(3'd6, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 12'd0);
    tick();
    idle();
    check("ill_valid", 32'(bus.out_valid), 32'd0);
    check("ill_err", 32'(err_illegal), 32'd1);
    check("ill_addr", bus.out_addr, 32'hC);
    check("ill_in_ready", 32'(bus.in_ready), 32'd1);
    drive(3'd1, 5'd7, 5'd8, 5'd0, 3'b000, 7'h7F, 12'h123);
    tick();
    idle();
    check("ill_next_inst", bus.out_inst, 32'h12340393);
    check("ill_next_addr", bus.out_addr, 32'hC);
    tick();
    check("ill_wrap_addr", bus.out_addr, 32'h0);
    check("ill_err_sticky", 32'(err_illegal), 32'd1);
    do_reset();
    check("ill_err_cleared", 32'(err_illegal), 32'd0);

    // Flush with output and skid full, new input valid, transfer-ready
    drive(3'd4, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0);
    tick();
    idle();
    tick();
    check("fl_pre_addr", bus.out_addr, 32'h4);
    bus.out_ready = 1'b0;
    drive(3'd0, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 12'd0);
    tick();
    drive(3'd2, 5'd2, 5'd3, 5'd0, 3'b010, 7'd0, 12'h010);
    tick();
    check("fl_full_in_ready", 32'(bus.in_ready), 32'd0);
    drive(3'd3, 5'd0, 5'd6, 5'd5, 3'd0, 7'd0, 12'hFE0);
    flush = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    check("fl_valid", 32'(bus.out_valid), 32'd0);
    check("fl_in_ready", 32'(bus.in_ready), 32'd1);
    check("fl_addr", bus.out_addr, 32'h4);
    tick();
    check("fl_skid_gone", 32'(bus.out_valid), 32'd0);
    drive(3'd0, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 12'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    check("fl_drop_input", 32'(bus.out_valid), 32'd0);
    check("fl_drop_addr", bus.out_addr, 32'h4);

    // Reset mid-stream
    bus.out_ready = 1'b0;
    drive(3'd0, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 12'd0);
    tick();
    drive(3'd4, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0);
    tick();
    idle();
    reset = 1'b1;
    tick();
    check("mrst_valid", 32'(bus.out_valid), 32'd0);
    check("mrst_addr", bus.out_addr, 32'h0);
    check("mrst_in_ready", 32'(bus.in_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("mrst_in_ready_back", 32'(bus.in_ready), 32'd1);
    tick();
    check("mrst_no_skid_word", 32'(bus.out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
